fan_row_collector: RTL and testbench
====================================

Name: fan_row_collector

Overview:
- Sits directly downstream of the last FAN adder stage (8-lane, 16-bit line).
- Each accepted cycle, every lane flagged valid (ctrl[3]=1) carries a partial sum tagged with an output row.
- The block accumulates per-row totals across cycles of one tile.
- On end-of-tile it drains the touched rows, one per beat, over a valid/ready output port, then clears for the next tile.

Parameters:
- DW_DATA, 8, lane data width (unsigned).
- DW_ROW, 4, lane row-tag width.
- DW_CTRL, 4, lane control width; bit DW_CTRL-1 = lane valid.
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL, lane width; layout {ctrl, row, data} with data in the LSBs.
- NUM_IN, 8, lanes per input beat.
- NUM_ROW, 1<<DW_ROW, number of accumulator rows.
- DW_ACC, 20, accumulator/output data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  collector can accept a beat.
- in  in  NUM_IN*DW_LINE  lane bundle; lane i at [i*DW_LINE +: DW_LINE].
- in_last  in  1  qualifies the final beat of a tile.
- out_valid  out  1  drained row result valid.
- out_ready  in  1  consumer accepts the result.
- out_row  out  DW_ROW  row index of the result.
- out_data  out  DW_ACC  accumulated row total.
- out_last  out  1  final result beat of the tile.
- tile_done  out  1  one-cycle pulse when a tile is fully drained.

Behaviour:
- Reset (rst=0, async):
  - state=ACC; all accumulators 0; hit bitmap 0.
  - out_valid=0, out_row=0, out_data=0, out_last=0, tile_done=0.
  - in_ready=1 from the first clock edge after release.
- Beat accepted when in_valid & in_ready.
- For each row r, the cycle sum is the total of zero-extended data from all lanes with ctrl[3]=1 and row==r.
  - Several lanes may hit the same row in one beat; all are summed.
  - Lanes with ctrl[3]=0 are ignored regardless of other bits.
- acc[r] <= acc[r] + cycle sum at the accepting edge.
  - Addition wraps modulo 2^DW_ACC (default build).
  - hit[r] is set if any valid lane targeted r, including lanes with data 0.
- States:
  - ACC: in_ready=1, out_valid=0. An accepted beat with in_last=1 is accumulated, then the FSM goes to DRAIN, or to DONE if hit is all-zero after that beat.
  - DRAIN: in_ready=0.
    - out_valid=1, out_row = lowest set hit index, out_data=acc[out_row].
    - out_last=1 when exactly one hit bit remains.
    - On out_ready: clear hit[out_row] and acc[out_row]. If out_last, go to DONE.
    - Outputs must be held stable while out_valid & !out_ready.
  - DONE: tile_done=1 for exactly one cycle, in_ready=0, then return to ACC.
- Latency:
  - First out_valid is 1 cycle after the in_last edge.
  - k touched rows with out_ready held high take k cycles, then 1 DONE cycle.
  - Earliest next-tile beat is accepted 2 cycles after the out_last handshake.
- Boundaries:
  - in_valid while in_ready=0: the beat is not consumed, and the producer holds it.
  - All NUM_IN lanes on one row at max data: worst-case per-beat add is NUM_IN*(2^DW_DATA-1).
  - Empty tile (in_last on a beat with no valid lanes and no prior hits): no output beats; tile_done pulses.
  - Reset mid-drain: remaining rows are discarded, with no partial output after release.

Optional Feature:
- Macro FAN_COLLECT_SAT_EN.
- Defined:
  - Accumulate saturates at 2^DW_ACC-1 instead of wrapping.
  - Adds output port sat_flag (1 bit), valid with out_valid, set if that row saturated during the tile.
  - sat_flag clears with the row.
- Undefined: wraparound, and no sat_flag port.

Decomposition:
- Shared package fan_pkg:
  - Line field offsets (DATA_LSB=0, ROW_LSB=DW_DATA, CTRL_LSB=DW_DATA+DW_ROW).
  - CTRL_VALID_BIT=DW_CTRL-1.
  - Collector state enum {ACC, DRAIN, DONE}.
- One sub-module, fan_row_lane_sum: purely combinational per-row lane-sum (NUM_IN lanes to NUM_ROW sums, width DW_DATA+clog2(NUM_IN)).

Test Plan:
- Reset, then one beat: lanes0-3 row 2 data 10, lanes4-7 row 5 data 3, in_last=1, out_ready=1 -> beats (row2,40,last=0), (row5,12,last=1), then tile_done pulse.
- Three beats, each with lane0 row 7 data 255 and other lanes invalid; last beat in_last -> single beat row7 data 765 with out_last=1.
- Hold out_ready=0 for 5 cycles in DRAIN -> out_row/out_data stable, in_ready=0; releasing emits the same beat once.
- Empty tile: in_last with all ctrl[3]=0 -> zero out_valid cycles, tile_done 1 cycle after acceptance, in_ready back next cycle.
- Wrap/sat: preload row 0 near 2^20-1 (4112 beats of 8x255) -> default build wraps modulo 2^20; with FAN_COLLECT_SAT_EN, out_data=0xFFFFF and sat_flag=1.
- Assert rst low during the second drain beat -> outputs zero immediately; after release, a new tile yields only its own sums.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared widths, line field offsets, collector state encoding and bitmap helpers
// for the FAN row collector.
package fan_pkg;

    localparam int DW_DATA        = 8;
    localparam int DW_ROW         = 4;
    localparam int DW_CTRL        = 4;
    localparam int DW_LINE        = DW_DATA + DW_ROW + DW_CTRL;
    localparam int NUM_IN         = 8;
    localparam int NUM_ROW        = 1 << DW_ROW;
    localparam int DW_ACC         = 20;
    localparam int DW_SUM         = DW_DATA + $clog2(NUM_IN);

    localparam int DATA_LSB       = 0;
    localparam int ROW_LSB        = DW_DATA;
    localparam int CTRL_LSB       = DW_DATA + DW_ROW;
    localparam int CTRL_VALID_BIT = DW_CTRL - 1;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } coll_state_e;

    // Lowest set index of a row bitmap; 0 when the bitmap is empty.
    function automatic logic [DW_ROW-1:0] first_set(input logic [NUM_ROW-1:0] v);
        first_set = '0;
        for (int i = NUM_ROW - 1; i >= 0; i--) begin
            if (v[i]) first_set = DW_ROW'(i);
        end
    endfunction

    function automatic logic single_bit(input logic [NUM_ROW-1:0] v);
        single_bit = (v != '0) && ((v & (v - NUM_ROW'(1))) == '0);
    endfunction

endpackage

// File: rtl/fan_row_lane_sum.sv
// Combinational scatter-add of one input line into per-row sums and a row-hit map.
module fan_row_lane_sum
    import fan_pkg::*;
(
    input  logic [NUM_IN*DW_LINE-1:0]      lanes,
    output logic [NUM_ROW-1:0][DW_SUM-1:0] row_sum,
    output logic [NUM_ROW-1:0]             row_hit
);

    // Invalid lanes contribute zero and never mark a row, whatever their other bits.
    always_comb begin
        row_sum = '0;
        row_hit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            row_sum[lanes[i*DW_LINE+ROW_LSB +: DW_ROW]] =
                row_sum[lanes[i*DW_LINE+ROW_LSB +: DW_ROW]] +
                (lanes[i*DW_LINE+CTRL_LSB+CTRL_VALID_BIT] ?
                    DW_SUM'(lanes[i*DW_LINE+DATA_LSB +: DW_DATA]) : DW_SUM'(0));
            row_hit[lanes[i*DW_LINE+ROW_LSB +: DW_ROW]] =
                row_hit[lanes[i*DW_LINE+ROW_LSB +: DW_ROW]] |
                lanes[i*DW_LINE+CTRL_LSB+CTRL_VALID_BIT];
        end
    end

endmodule

// File: rtl/fan_row_collector.sv
// Per-row tile accumulator that drains touched rows over valid/ready after in_last.
// FAN_COLLECT_SAT_EN selects saturating accumulation and adds the sat_flag output.
module fan_row_collector
    import fan_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*DW_LINE-1:0] in,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW_ROW-1:0]         out_row,
    output logic [DW_ACC-1:0]         out_data,
    output logic                      out_last,
    output logic                      tile_done
`ifdef FAN_COLLECT_SAT_EN
    ,
    output logic                      sat_flag
`endif
);

    coll_state_e                     state_q, state_d;
    logic [NUM_ROW-1:0][DW_ACC-1:0]  acc_q, acc_d;
    logic [NUM_ROW-1:0]              hit_q, hit_d;
    logic [NUM_ROW-1:0][DW_SUM-1:0]  row_sum_s;
    logic [NUM_ROW-1:0]              row_hit_s;
    logic [DW_ROW-1:0]               first_row_s;
    logic                            in_ready_q, in_ready_d;
    logic                            out_valid_q, out_valid_d;
    logic [DW_ROW-1:0]               out_row_q, out_row_d;
    logic [DW_ACC-1:0]               out_data_q, out_data_d;
    logic                            out_last_q, out_last_d;
    logic                            tile_done_q, tile_done_d;
`ifdef FAN_COLLECT_SAT_EN
    logic [NUM_ROW-1:0][DW_ACC:0]    sum_ext_s;
    logic [NUM_ROW-1:0]              sat_q, sat_d;
    logic                            sat_flag_q, sat_flag_d;
`else
    logic [NUM_ROW-1:0][DW_ACC-1:0]  sum_ext_s;
`endif

    fan_row_lane_sum u_lane_sum (
        .lanes   (in),
        .row_sum (row_sum_s),
        .row_hit (row_hit_s)
    );

    // Candidate new totals; the extra top bit flags overflow in the saturating build.
    always_comb begin
        for (int r = 0; r < NUM_ROW; r++) begin
`ifdef FAN_COLLECT_SAT_EN
            sum_ext_s[r] = {1'b0, acc_q[r]} + (DW_ACC+1)'(row_sum_s[r]);
`else
            sum_ext_s[r] = acc_q[r] + DW_ACC'(row_sum_s[r]);
`endif
        end
    end

    // Next accumulator/hit/state; in DRAIN the registered out_row is the row being retired.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        hit_d   = hit_q;
`ifdef FAN_COLLECT_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            ST_ACC: begin
                if (in_valid && in_ready_q) begin
                    for (int r = 0; r < NUM_ROW; r++) begin
`ifdef FAN_COLLECT_SAT_EN
                        acc_d[r] = sum_ext_s[r][DW_ACC] ? {DW_ACC{1'b1}} : sum_ext_s[r][DW_ACC-1:0];
                        sat_d[r] = sat_q[r] | sum_ext_s[r][DW_ACC];
`else
                        acc_d[r] = sum_ext_s[r];
`endif
                    end
                    hit_d = hit_q | row_hit_s;
                    if (in_last) begin
                        state_d = (hit_d != '0) ? ST_DRAIN : ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    hit_d[out_row_q] = 1'b0;
                    acc_d[out_row_q] = '0;
`ifdef FAN_COLLECT_SAT_EN
                    sat_d[out_row_q] = 1'b0;
`endif
                    state_d = out_last_q ? ST_DONE : ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // Outputs are computed from next state so they register in step with the FSM.
    always_comb begin
        first_row_s = first_set(hit_d);
        out_valid_d = (state_d == ST_DRAIN);
        out_row_d   = out_valid_d ? first_row_s : '0;
        out_data_d  = out_valid_d ? acc_d[first_row_s] : '0;
        out_last_d  = out_valid_d & single_bit(hit_d);
        tile_done_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_ACC);
`ifdef FAN_COLLECT_SAT_EN
        sat_flag_d  = out_valid_d & sat_d[first_row_s];
`endif
    end

    // State, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            hit_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            tile_done_q <= 1'b0;
`ifdef FAN_COLLECT_SAT_EN
            sat_q       <= '0;
            sat_flag_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            hit_q       <= hit_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            tile_done_q <= tile_done_d;
`ifdef FAN_COLLECT_SAT_EN
            sat_q       <= sat_d;
            sat_flag_q  <= sat_flag_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign tile_done = tile_done_q;
`ifdef FAN_COLLECT_SAT_EN
    assign sat_flag  = sat_flag_q;
`endif

endmodule

// File: tb/tb_fan_row_collector.sv
// Randomised self-checking bench for fan_row_collector with a row-total reference model.
module tb_fan_row_collector;

    localparam int          LANES   = 8;
    localparam int          LW      = 16;
    localparam int unsigned ACC_MAX = (32'd1 << 20) - 32'd1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [LANES*LW-1:0] in_bus;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_row;
    logic [19:0]      out_data;
    logic             out_last;
    logic             tile_done;
`ifdef FAN_COLLECT_SAT_EN
    logic             sat_flag;
`endif

    int checks = 0;
    int passed = 0;

    int unsigned m_acc [16];
    bit          m_hit [16];
    bit          m_sat [16];

    always #5 clk = ~clk;

    fan_row_collector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_bus),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_data  (out_data),
        .out_last  (out_last),
`ifdef FAN_COLLECT_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .tile_done (tile_done)
    );

    function automatic logic [15:0] mk_lane(input logic v, input logic [2:0] lo,
                                            input logic [3:0] row, input logic [7:0] d);
        return {v, lo, row, d};
    endfunction

    function automatic logic [15:0] rnd_lane();
        logic [7:0] d;
        d = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        return mk_lane(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       4'($urandom_range(0, 15)), d);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 16; r++) begin
            m_acc[r] = 0;
            m_hit[r] = 1'b0;
            m_sat[r] = 1'b0;
        end
    endtask

    task automatic model_beat(input logic [LANES*LW-1:0] bus);
        logic [15:0] ln;
        int unsigned s;
        for (int i = 0; i < LANES; i++) begin
            ln = bus[i*LW +: LW];
            if (ln[15]) begin
                s = m_acc[ln[11:8]] + 32'(ln[7:0]);
`ifdef FAN_COLLECT_SAT_EN
                if (s > ACC_MAX) begin
                    s = ACC_MAX;
                    m_sat[ln[11:8]] = 1'b1;
                end
`else
                s = s % (ACC_MAX + 1);
`endif
                m_acc[ln[11:8]] = s;
                m_hit[ln[11:8]] = 1'b1;
            end
        end
    endtask

    task automatic send_beat(input logic [LANES*LW-1:0] bus, input logic last);
        int budget = 50;
        while (in_ready !== 1'b1 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        checks++;
        if (in_ready !== 1'b1) $display("FAIL in_ready_wait got %b want 1", in_ready);
        else passed++;
        in_valid = 1'b1;
        in_bus   = bus;
        in_last  = last;
        if (in_ready === 1'b1) model_beat(bus);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the in_last edge: checks every drain beat, then DONE and return to ACC.
    task automatic drain_check(input bit random_ready);
        int   exp_q[$];
        int   budget = 200;
        logic rdy;
        for (int r = 0; r < 16; r++) if (m_hit[r]) exp_q.push_back(r);
        while (exp_q.size() > 0 && budget > 0) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_row !== 4'(exp_q[0]) ||
                out_data !== 20'(m_acc[exp_q[0]]) || out_last !== (exp_q.size() == 1))
                $display("FAIL drain_beat got v=%b rdy=%b row=%0d data=%0d last=%b want v=1 rdy=0 row=%0d data=%0d last=%b",
                         out_valid, in_ready, out_row, out_data, out_last,
                         exp_q[0], m_acc[exp_q[0]], exp_q.size() == 1);
            else passed++;
`ifdef FAN_COLLECT_SAT_EN
            checks++;
            if (sat_flag !== m_sat[exp_q[0]])
                $display("FAIL sat_flag got %b want %b", sat_flag, m_sat[exp_q[0]]);
            else passed++;
`endif
            rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            @(posedge clk); #1;
            if (rdy) void'(exp_q.pop_front());
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL drain_budget got %0d rows left want 0", exp_q.size());
        else passed++;
        checks++;
        if (tile_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL done_cycle got done=%b v=%b rdy=%b want 1 0 0", tile_done, out_valid, in_ready);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (tile_done !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL back_to_acc got done=%b rdy=%b want 0 1", tile_done, in_ready);
        else passed++;
        out_ready = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_bus = '0; in_last = 1'b0; out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || tile_done !== 1'b0 ||
            out_row !== 4'd0 || out_data !== 20'd0)
            $display("FAIL reset_outputs got v=%b last=%b done=%b row=%0d data=%0d want all 0",
                     out_valid, out_last, tile_done, out_row, out_data);
        else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release got rdy=%b v=%b want 1 0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_basic();
        logic [LANES*LW-1:0] bus;
        for (int i = 0; i < 4; i++) bus[i*LW +: LW] = mk_lane(1'b1, 3'd0, 4'd2, 8'd10);
        for (int i = 4; i < 8; i++) bus[i*LW +: LW] = mk_lane(1'b1, 3'd0, 4'd5, 8'd3);
        send_beat(bus, 1'b1);
        checks++;
        if (out_row !== 4'd2 || out_data !== 20'd40 || out_last !== 1'b0)
            $display("FAIL basic_first got row=%0d data=%0d last=%b want 2 40 0", out_row, out_data, out_last);
        else passed++;
        drain_check(1'b0);
    endtask

    task automatic test_multi_beat();
        logic [LANES*LW-1:0] bus;
        for (int b = 0; b < 3; b++) begin
            for (int i = 1; i < 8; i++) bus[i*LW +: LW] = {1'b0, rnd_lane() & 16'h7FFF};
            bus[0 +: LW] = mk_lane(1'b1, 3'd0, 4'd7, 8'd255);
            send_beat(bus, b == 2);
        end
        checks++;
        if (out_row !== 4'd7 || out_data !== 20'd765 || out_last !== 1'b1)
            $display("FAIL multi_beat got row=%0d data=%0d last=%b want 7 765 1", out_row, out_data, out_last);
        else passed++;
        drain_check(1'b0);
    endtask

    task automatic test_hold();
        logic [LANES*LW-1:0] bus;
        bus = '0;
        bus[0 +: LW]  = mk_lane(1'b1, 3'd0, 4'd4, 8'd20);
        bus[LW +: LW] = mk_lane(1'b1, 3'd0, 4'd11, 8'd9);
        out_ready = 1'b0;
        send_beat(bus, 1'b1);
        bus[0 +: LW] = mk_lane(1'b1, 3'd0, 4'd4, 8'd100);
        in_valid = 1'b1;
        in_bus   = bus;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_row !== 4'd4 || out_data !== 20'd20 || in_ready !== 1'b0)
                $display("FAIL hold_stable got v=%b row=%0d data=%0d rdy=%b want 1 4 20 0",
                         out_valid, out_row, out_data, in_ready);
            else passed++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain_check(1'b0);
    endtask

    task automatic test_empty();
        logic [LANES*LW-1:0] bus;
        for (int i = 0; i < 8; i++) bus[i*LW +: LW] = {1'b0, rnd_lane() & 16'h7FFF};
        send_beat(bus, 1'b1);
        drain_check(1'b0);
    endtask

    task automatic test_random_tiles(input int n, input bit random_ready);
        logic [LANES*LW-1:0] bus;
        int beats;
        for (int t = 0; t < n; t++) begin
            beats = $urandom_range(1, 4);
            for (int b = 0; b < beats; b++) begin
                for (int i = 0; i < 8; i++) bus[i*LW +: LW] = rnd_lane();
                send_beat(bus, b == beats - 1);
            end
            drain_check(random_ready);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [LANES*LW-1:0] bus;
        for (int i = 0; i < 8; i++) bus[i*LW +: LW] = mk_lane(1'b1, 3'd0, 4'd0, 8'd255);
        for (int b = 0; b < 4113; b++) send_beat(bus, b == 4112);
        checks++;
`ifdef FAN_COLLECT_SAT_EN
        if (out_data !== 20'hFFFFF || sat_flag !== 1'b1)
            $display("FAIL sat_value got data=%0h sat=%b want fffff 1", out_data, sat_flag);
`else
        if (out_data !== 20'd1912)
            $display("FAIL wrap_value got data=%0d want 1912", out_data);
`endif
        else passed++;
        drain_check(1'b0);
    endtask

    task automatic test_mid_reset();
        logic [LANES*LW-1:0] bus;
        bus = '0;
        bus[0 +: LW]    = mk_lane(1'b1, 3'd0, 4'd1, 8'd5);
        bus[LW +: LW]   = mk_lane(1'b1, 3'd0, 4'd3, 8'd6);
        bus[2*LW +: LW] = mk_lane(1'b1, 3'd0, 4'd9, 8'd7);
        out_ready = 1'b1;
        send_beat(bus, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (out_row !== 4'd3 || out_data !== 20'd6)
            $display("FAIL mid_second_beat got row=%0d data=%0d want 3 6", out_row, out_data);
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_row !== 4'd0 || out_data !== 20'd0 || out_last !== 1'b0)
            $display("FAIL mid_reset_zero got v=%b row=%0d data=%0d last=%b want 0 0 0 0",
                     out_valid, out_row, out_data, out_last);
        else passed++;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL mid_reset_release got rdy=%b v=%b want 1 0", in_ready, out_valid);
        else passed++;
        bus = '0;
        bus[0 +: LW] = mk_lane(1'b1, 3'd0, 4'd3, 8'd1);
        send_beat(bus, 1'b1);
        drain_check(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_beat();
        test_hold();
        test_empty();
        test_random_tiles(6, 1'b0);
        test_random_tiles(6, 1'b1);
        test_back_to_back_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
